// File: rtl/pwm_dead_time_if.sv
// Gate-drive bundle between the duty comparator side and the dead-time generator.
// The master drives the enable, PWM and dead count; the slave returns the gate pair.
interface pwm_dead_time_if #(
  parameter int DT_WIDTH = 8
);
  logic                En;
  logic                PWM_In;
  logic [DT_WIDTH-1:0] Dead_Cnt;
  logic                Gate_H;
  logic                Gate_L;
  logic                Swallow;

  modport master (
    output En, PWM_In, Dead_Cnt,
    input  Gate_H, Gate_L, Swallow
  );

  modport slave (
    input  En, PWM_In, Dead_Cnt,
    output Gate_H, Gate_L, Swallow
  );
endinterface

// File: rtl/pwm_dead_time.sv
// Complementary half-bridge gate driver with programmable dead time and
// suppression of PWM pulses shorter than the dead interval.
module pwm_dead_time #(
  parameter int DT_WIDTH = 8,
  parameter int DT_MIN   = 1
) (
  input logic             CLK,
  input logic             Reset,
  pwm_dead_time_if.slave  bus
);

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    DEAD_TO_H = 3'd1,
    ON_H      = 3'd2,
    DEAD_TO_L = 3'd3,
    ON_L      = 3'd4
  } state_t;

  localparam logic [DT_WIDTH-1:0] DT_MIN_V = DT_WIDTH'(DT_MIN);
  localparam logic [DT_WIDTH-1:0] ONE_V    = DT_WIDTH'(1);

  state_t              state_reg;
  logic                pwm_reg;
  logic [DT_WIDTH-1:0] cnt_reg;
  logic                gate_h_reg;
  logic                gate_l_reg;
  logic                swallow_reg;
  logic [DT_WIDTH-1:0] dt_eff;

  // Never allow a zero-length dead interval, whatever the programmed count.
  always_comb begin
    dt_eff = (bus.Dead_Cnt < DT_MIN_V) ? DT_MIN_V : bus.Dead_Cnt;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg   <= OFF;
      pwm_reg     <= 1'b0;
      cnt_reg     <= '0;
      gate_h_reg  <= 1'b0;
      gate_l_reg  <= 1'b0;
      swallow_reg <= 1'b0;
    end else begin
      pwm_reg     <= bus.PWM_In;
      swallow_reg <= 1'b0;
      if (!bus.En) begin
        state_reg  <= OFF;
        cnt_reg    <= '0;
        gate_h_reg <= 1'b0;
        gate_l_reg <= 1'b0;
      end else begin
        case (state_reg)
          OFF: begin
            cnt_reg    <= dt_eff;
            gate_h_reg <= 1'b0;
            gate_l_reg <= 1'b0;
            state_reg  <= pwm_reg ? DEAD_TO_H : DEAD_TO_L;
          end
          DEAD_TO_H: begin
            if (!pwm_reg) begin
              state_reg   <= DEAD_TO_L;
              cnt_reg     <= dt_eff;
              swallow_reg <= 1'b1;
            end else if (cnt_reg <= ONE_V) begin
              state_reg  <= ON_H;
              gate_h_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - ONE_V;
            end
          end
          ON_H: begin
            if (!pwm_reg) begin
              state_reg  <= DEAD_TO_L;
              cnt_reg    <= dt_eff;
              gate_h_reg <= 1'b0;
            end
          end
          DEAD_TO_L: begin
            if (pwm_reg) begin
              state_reg   <= DEAD_TO_H;
              cnt_reg     <= dt_eff;
              swallow_reg <= 1'b1;
            end else if (cnt_reg <= ONE_V) begin
              state_reg  <= ON_L;
              gate_l_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - ONE_V;
            end
          end
          ON_L: begin
            if (pwm_reg) begin
              state_reg  <= DEAD_TO_H;
              cnt_reg    <= dt_eff;
              gate_l_reg <= 1'b0;
            end
          end
          default: begin
            state_reg  <= OFF;
            cnt_reg    <= '0;
            gate_h_reg <= 1'b0;
            gate_l_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Gate_H  = gate_h_reg;
  assign bus.Gate_L  = gate_l_reg;
  assign bus.Swallow = swallow_reg;

endmodule

// File: tb/tb_pwm_dead_time.sv
// Randomized bench for pwm_dead_time checked cycle by cycle against an
// abstract "target side plus remaining wait" reference model.
module tb_pwm_dead_time;

  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_fail;

  pwm_dead_time_if #(.DT_WIDTH(8)) bus ();

  pwm_dead_time #(.DT_WIDTH(8), .DT_MIN(1)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: which gate the bridge is heading for and how many
  // cycles of dead time are still owed before that gate may turn on.
  bit m_pwm_r;
  bit m_active;
  bit m_tgt;
  int m_wait;
  bit m_gh;
  bit m_gl;
  bit m_sw;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit rst, input bit en, input bit pwm, input int dc);
    int d;
    d = (dc < 1) ? 1 : dc;
    m_sw = 1'b0;
    if (rst) begin
      m_pwm_r  = 1'b0;
      m_active = 1'b0;
      m_tgt    = 1'b0;
      m_wait   = 0;
    end else begin
      if (!en) begin
        m_active = 1'b0;
        m_wait   = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_tgt    = m_pwm_r;
        m_wait   = d;
      end else if (m_pwm_r != m_tgt) begin
        if (m_wait > 0) m_sw = 1'b1;
        m_tgt  = m_pwm_r;
        m_wait = d;
      end else if (m_wait > 0) begin
        m_wait--;
      end
      m_pwm_r = pwm;
    end
    m_gh = m_active && (m_wait == 0) && m_tgt;
    m_gl = m_active && (m_wait == 0) && !m_tgt;
  endfunction

  // One clock: drive inputs, advance model across the edge, compare after it.
  task automatic step(input bit rst, input bit en, input bit pwm, input int dc);
    Reset        = rst;
    bus.En       = en;
    bus.PWM_In   = pwm;
    bus.Dead_Cnt = 8'(dc);
    @(posedge CLK);
    model_edge(rst, en, pwm, dc);
    #1;
    check_eq("gate_h", int'(bus.Gate_H), int'(m_gh));
    check_eq("gate_l", int'(bus.Gate_L), int'(m_gl));
    check_eq("swallow", int'(bus.Swallow), int'(m_sw));
    check_eq("no_overlap", int'(bus.Gate_H & bus.Gate_L), 0);
  endtask

  initial begin
    int lat;
    int cnt_h;
    int cnt_l;
    int cnt_sw;
    int max_h;
    int off_cnt;
    bit lvl;
    int run;
    int dc;
    bit en;

    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b1;
    bus.En = 1'b0;
    bus.PWM_In = 1'b0;
    bus.Dead_Cnt = 8'd0;
    model_edge(1'b1, 1'b0, 1'b0, 0);

    // Reset held with PWM high and enable on, then latency to first Gate_H.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 4);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 1, 1, 4);
      lat++;
      if (bus.Gate_H) break;
    end
    check_eq("rst_to_gate_h", lat, 6);
    $display("reset release: Gate_H after %0d cycles", lat);

    // 20/20 square wave with dead count 4; period 2 is measured in full.
    for (int p = 0; p < 3; p++) begin
      cnt_h = 0;
      cnt_l = 0;
      for (int i = 0; i < 40; i++) begin
        step(0, 1, (i < 20), 4);
        cnt_h += int'(bus.Gate_H);
        cnt_l += int'(bus.Gate_L);
      end
      if (p == 1) begin
        check_eq("sq_gate_h_cycles", cnt_h, 16);
        check_eq("sq_gate_l_cycles", cnt_l, 16);
      end
      $display("square period %0d: Gate_H %0d Gate_L %0d", p, cnt_h, cnt_l);
    end

    // Dead count 0 still enforces one dead cycle.
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 10; i++) step(0, 1, (i < 5), 0);
    $display("dead_cnt=0 square wave done");

    // Short pulse inside a 6-cycle dead time is swallowed.
    for (int i = 0; i < 30; i++) step(0, 1, 0, 6);
    cnt_sw = 0;
    max_h  = 0;
    for (int i = 0; i < 25; i++) begin
      step(0, 1, (i < 3), 6);
      cnt_sw += int'(bus.Swallow);
      if (bus.Gate_H) max_h = 1;
    end
    check_eq("pulse_swallow_count", cnt_sw, 1);
    check_eq("pulse_gate_h_seen", max_h, 0);
    $display("short pulse: %0d swallow pulses", cnt_sw);

    // Enable dropped while high side is on, then re-enabled with PWM low.
    for (int i = 0; i < 25; i++) step(0, 1, 1, 4);
    check_eq("on_h_before_en_drop", int'(bus.Gate_H), 1);
    step(0, 0, 0, 4);
    check_eq("en_drop_gate_h", int'(bus.Gate_H), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0, 4);
      lat++;
      if (bus.Gate_L) break;
    end
    check_eq("reenable_to_gate_l", lat, 5);
    $display("re-enable: Gate_L after %0d cycles", lat);

    // 100% then 0% duty, 1000 cycles each.
    for (int i = 0; i < 1000; i++) step(0, 1, 1, 3);
    for (int i = 0; i < 1000; i++) step(0, 1, 0, 3);
    $display("constant duty holds done");

    // Maximum dead count must not wrap.
    for (int i = 0; i < 5; i++) step(0, 1, 0, 255);
    off_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step(0, 1, 1, 255);
      if (bus.Gate_H) break;
      if (!bus.Gate_L) off_cnt++;
    end
    check_eq("dead_255_interval", off_cnt, 255);
    $display("dead_cnt=255: both-off for %0d cycles", off_cnt);

    // Random runs with mid-interval Dead_Cnt changes, enable drops and resets.
    lvl = 1'b0;
    for (int r = 0; r < 300; r++) begin
      run = $urandom_range(1, 14);
      dc  = $urandom_range(0, 9);
      en  = ($urandom_range(0, 19) != 0);
      lvl = $urandom_range(0, 1);
      if ($urandom_range(0, 49) == 0) step(1, en, lvl, dc);
      for (int i = 0; i < run; i++) begin
        if ($urandom_range(0, 3) == 0) dc = $urandom_range(0, 9);
        step(0, en, lvl, dc);
      end
    end
    $display("random phase done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
